// File: rtl/inst_mem_loader_pkg.sv
// Shared constants and state encoding for the instruction memory loader.
package inst_mem_loader_pkg;

  localparam int LDR_INST_LENGTH    = 32;
  localparam int INSTMEM_ADDR_WIDTH = 8;

  typedef enum logic [2:0] {
    LDR_IDLE   = 3'd0,
    LDR_CNT_HI = 3'd1,
    LDR_CNT_LO = 3'd2,
    LDR_DATA   = 3'd3,
    LDR_FINISH = 3'd4,
    LDR_DONE   = 3'd5
  } ldr_state_t;

  function automatic int bytes_per_word(input int width);
    return width / 8;
  endfunction

endpackage

// File: rtl/inst_mem_loader_assembler.sv
// Byte-to-word assembler: shifts host bytes in MSB-first and flags the byte that completes a word.
module inst_word_assembler
  import inst_mem_loader_pkg::*;
#(
  parameter int WIDTH = LDR_INST_LENGTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             accept,
  input  logic [7:0]       byte_data,
  output logic             word_last,
  output logic [WIDTH-1:0] word_next
);

  localparam int BYTES = bytes_per_word(WIDTH);
  localparam int CW    = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [CW-1:0] LAST_BYTE = CW'(BYTES - 1);

  logic [WIDTH-1:0] shift_q;
  logic [CW-1:0]    byte_cnt;

  // word_next already contains the byte being accepted, so the top can register it directly
  assign word_next = (shift_q << 8) | WIDTH'(byte_data);
  assign word_last = accept && (byte_cnt == LAST_BYTE);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      shift_q  <= '0;
      byte_cnt <= '0;
    end else if (accept) begin
      shift_q  <= word_next;
      byte_cnt <= (byte_cnt == LAST_BYTE) ? '0 : byte_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/inst_mem_loader.sv
// Instruction memory write-side loader: parses [count_hi, count_lo, words...] from a host byte
// stream, writes words from BASE_ADDR upward and holds the Scheduler in reset while loading.
module inst_mem_loader #(
  parameter int          INST_LENGTH = inst_mem_loader_pkg::LDR_INST_LENGTH,
  parameter int          ADDR_WIDTH  = inst_mem_loader_pkg::INSTMEM_ADDR_WIDTH,
  parameter int unsigned BASE_ADDR   = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [7:0]             byte_data,
  input  logic                   byte_valid,
  output logic                   byte_ready,
  output logic                   wr_en,
  output logic [ADDR_WIDTH-1:0]  wr_addr,
  output logic [INST_LENGTH-1:0] wr_data,
  output logic                   sched_hold,
  output logic                   done,
  output logic                   overflow
);

  import inst_mem_loader_pkg::*;

  localparam logic [16:0] ADDR_LIMIT = 17'((1 << ADDR_WIDTH) - 1);

  ldr_state_t state, next_state;

  logic [15:0]            word_count;
  logic [15:0]            word_idx;
  logic [16:0]            addr_full;
  logic                   in_range;
  logic                   xfer;
  logic                   data_xfer;
  logic                   start_ok;
  logic                   count_is_zero;
  logic                   last_word;
  logic                   word_last;
  logic [INST_LENGTH-1:0] word_next;

  assign xfer          = byte_valid && byte_ready;
  assign data_xfer     = xfer && (state == LDR_DATA);
  assign start_ok      = start && ((state == LDR_IDLE) || (state == LDR_DONE));
  assign count_is_zero = ({word_count[15:8], byte_data} == 16'd0);
  // Wide enough that addresses past the top of memory never wrap back into range
  assign addr_full     = 17'(BASE_ADDR) + {1'b0, word_idx};
  assign in_range      = (addr_full <= ADDR_LIMIT);
  assign last_word     = word_last && (({1'b0, word_idx} + 17'd1) == {1'b0, word_count});

  inst_word_assembler #(
    .WIDTH(INST_LENGTH)
  ) u_assembler (
    .clk       (clk),
    .reset     (reset),
    .clear     (start_ok),
    .accept    (data_xfer),
    .byte_data (byte_data),
    .word_last (word_last),
    .word_next (word_next)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= LDR_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    byte_ready = 1'b0;
    case (state)
      LDR_IDLE, LDR_DONE: begin
        if (start) next_state = LDR_CNT_HI;
      end
      LDR_CNT_HI: begin
        byte_ready = 1'b1;
        if (xfer) next_state = LDR_CNT_LO;
      end
      LDR_CNT_LO: begin
        byte_ready = 1'b1;
        if (xfer) next_state = count_is_zero ? LDR_FINISH : LDR_DATA;
      end
      LDR_DATA: begin
        byte_ready = 1'b1;
        if (last_word) next_state = LDR_FINISH;
      end
      LDR_FINISH: begin
        next_state = LDR_DONE;
      end
      default: begin
        next_state = LDR_IDLE;
      end
    endcase
  end

  // Counters, write port, hold and status flags; wr_addr/wr_data keep their last values between writes
  always_ff @(posedge clk) begin
    if (reset) begin
      word_count <= '0;
      word_idx   <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= ADDR_WIDTH'(BASE_ADDR);
      wr_data    <= '0;
      sched_hold <= 1'b0;
      done       <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      done  <= 1'b0;
      if (start_ok) begin
        sched_hold <= 1'b1;
        overflow   <= 1'b0;
        word_idx   <= '0;
      end
      if (xfer && state == LDR_CNT_HI) word_count[15:8] <= byte_data;
      if (xfer && state == LDR_CNT_LO) word_count[7:0]  <= byte_data;
      if (word_last) begin
        word_idx <= word_idx + 16'd1;
        if (in_range) begin
          wr_en   <= 1'b1;
          wr_addr <= addr_full[ADDR_WIDTH-1:0];
          wr_data <= word_next;
        end else begin
          overflow <= 1'b1;
        end
      end
      if (state == LDR_FINISH) begin
        sched_hold <= 1'b0;
        done       <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_inst_mem_loader.sv
// Self-checking bench for inst_mem_loader: two instances (base 0 and base FE) driven from one stream.
module tb_inst_mem_loader;

  logic        clk = 1'b0;
  logic        reset, start, byte_valid;
  logic [7:0]  byte_data;

  logic        byte_ready0, wr_en0, sched_hold0, done0, overflow0;
  logic [7:0]  wr_addr0;
  logic [31:0] wr_data0;
  logic        byte_ready1, wr_en1, sched_hold1, done1, overflow1;
  logic [7:0]  wr_addr1;
  logic [31:0] wr_data1;

  int checks = 0;
  int errors = 0;

  logic [39:0] wq0[$];
  logic [39:0] wq1[$];
  int          wt0[$];
  int          cycle = 0;
  int          done_cnt0 = 0;
  int          done_cnt1 = 0;
  logic        prev_hold0 = 1'b0;
  logic        prev_hold1 = 1'b0;
  logic [31:0] stim_words[$];
  logic [31:0] imem[256];

  typedef struct {
    int count;
    int gap;
    int inject;
    int exp_wr0;
    int exp_wr1;
    int exp_ovf0;
    int exp_ovf1;
  } load_vec_t;

  load_vec_t vecs[6];

  inst_mem_loader #(.INST_LENGTH(32), .ADDR_WIDTH(8), .BASE_ADDR(0)) dut (
    .clk(clk), .reset(reset), .start(start), .byte_data(byte_data), .byte_valid(byte_valid),
    .byte_ready(byte_ready0), .wr_en(wr_en0), .wr_addr(wr_addr0), .wr_data(wr_data0),
    .sched_hold(sched_hold0), .done(done0), .overflow(overflow0)
  );

  inst_mem_loader #(.INST_LENGTH(32), .ADDR_WIDTH(8), .BASE_ADDR(254)) dut_hi (
    .clk(clk), .reset(reset), .start(start), .byte_data(byte_data), .byte_valid(byte_valid),
    .byte_ready(byte_ready1), .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1),
    .sched_hold(sched_hold1), .done(done1), .overflow(overflow1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // Captures memory writes and checks that every done pulse ends a hold period
  always @(negedge clk) begin
    if (!reset) begin
      if (wr_en0) begin
        wq0.push_back({wr_addr0, wr_data0});
        wt0.push_back(cycle);
        imem[wr_addr0] = wr_data0;
      end
      if (wr_en1) wq1.push_back({wr_addr1, wr_data1});
      if (done0) begin
        done_cnt0++;
        checkOutput("done0_hold_drop", {62'd0, prev_hold0, sched_hold0}, 64'd2);
      end
      if (done1) begin
        done_cnt1++;
        checkOutput("done1_hold_drop", {62'd0, prev_hold1, sched_hold1}, 64'd2);
      end
    end
    prev_hold0 = sched_hold0;
    prev_hold1 = sched_hold1;
  end

  task automatic applyStimulus(input logic [7:0] b);
    int waited = 0;
    byte_data  = b;
    byte_valid = 1'b1;
    @(negedge clk);
    while (!byte_ready0 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!byte_ready0) begin
      checkOutput("byte_ready_timeout", 64'd0, 64'd1);
      byte_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    byte_valid = 1'b0;
  endtask

  task automatic gapWait(input int gap);
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulseStart();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Reference: word i goes to base+i when that fits in 8 bits, otherwise it only raises overflow
  task automatic compareWrites(input int count, input int base, input int which);
    int          nexp = 0;
    int          a;
    logic        ovf = 1'b0;
    logic [39:0] got;
    int          qsize;
    qsize = (which == 0) ? wq0.size() : wq1.size();
    for (int i = 0; i < count; i++) begin
      a = base + i;
      if (a <= 255) begin
        if (nexp < qsize) got = (which == 0) ? wq0[nexp] : wq1[nexp];
        else got = 'x;
        checkOutput($sformatf("write%0d_%0d", which, nexp), {24'd0, got}, {24'd0, a[7:0], stim_words[i]});
        nexp++;
      end else begin
        ovf = 1'b1;
      end
    end
    checkOutput($sformatf("write_count%0d", which), qsize, nexp);
    checkOutput($sformatf("overflow%0d", which), (which == 0) ? overflow0 : overflow1, ovf);
  endtask

  task automatic runLoad(input int count, input int gap, input int inject);
    int d0, d1, k, waited;
    logic [31:0] wv;
    wq0.delete();
    wq1.delete();
    wt0.delete();
    d0 = done_cnt0;
    d1 = done_cnt1;
    pulseStart();
    checkOutput("hold_after_start0", sched_hold0, 1);
    checkOutput("hold_after_start1", sched_hold1, 1);
    checkOutput("ovf_clear_on_start0", overflow0, 0);
    checkOutput("ovf_clear_on_start1", overflow1, 0);
    applyStimulus(count[15:8]);
    gapWait(gap);
    applyStimulus(count[7:0]);
    gapWait(gap);
    k = 0;
    for (int w = 0; w < count; w++) begin
      wv = stim_words[w];
      for (int b = 3; b >= 0; b--) begin
        if (k == inject) start = 1'b1;
        applyStimulus(wv[b*8 +: 8]);
        start = 1'b0;
        k++;
        gapWait(gap);
      end
    end
    waited = 0;
    while ((done_cnt0 == d0 || done_cnt1 == d1) && waited < 40) begin
      @(posedge clk);
      waited++;
    end
    repeat (2) @(posedge clk);
    #1;
    checkOutput("done_pulses0", done_cnt0 - d0, 1);
    checkOutput("done_pulses1", done_cnt1 - d1, 1);
    checkOutput("hold_released0", sched_hold0, 0);
    checkOutput("hold_released1", sched_hold1, 0);
    compareWrites(count, 0, 0);
    compareWrites(count, 254, 1);
    if (gap == 0) begin
      for (int i = 1; i < wt0.size(); i++)
        checkOutput("full_rate_spacing", wt0[i] - wt0[i-1], 4);
    end
  endtask

  task automatic fillRandom(input int count);
    stim_words.delete();
    for (int i = 0; i < count; i++) stim_words.push_back($urandom());
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [39:0] got;
    int cnt;

    vecs[0] = '{count: 1,   gap: 0, inject: -1, exp_wr0: 1,   exp_wr1: 1, exp_ovf0: 0, exp_ovf1: 0};
    vecs[1] = '{count: 2,   gap: 3, inject: -1, exp_wr0: 2,   exp_wr1: 2, exp_ovf0: 0, exp_ovf1: 0};
    vecs[2] = '{count: 3,   gap: 0, inject: -1, exp_wr0: 3,   exp_wr1: 2, exp_ovf0: 0, exp_ovf1: 1};
    vecs[3] = '{count: 4,   gap: 0, inject: 5,  exp_wr0: 4,   exp_wr1: 2, exp_ovf0: 0, exp_ovf1: 1};
    vecs[4] = '{count: 0,   gap: 2, inject: -1, exp_wr0: 0,   exp_wr1: 0, exp_ovf0: 0, exp_ovf1: 0};
    vecs[5] = '{count: 258, gap: 0, inject: -1, exp_wr0: 256, exp_wr1: 2, exp_ovf0: 1, exp_ovf1: 1};

    reset      = 1'b1;
    start      = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_byte_ready", byte_ready0, 0);
    checkOutput("rst_wr_en", wr_en0, 0);
    checkOutput("rst_wr_addr0", wr_addr0, 8'h00);
    checkOutput("rst_wr_addr1", wr_addr1, 8'hFE);
    checkOutput("rst_wr_data", wr_data0, 0);
    checkOutput("rst_hold", sched_hold0, 0);
    checkOutput("rst_done", done0, 0);
    checkOutput("rst_overflow", overflow0, 0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] basic two-word load");
    stim_words.delete();
    stim_words.push_back(32'hDEADBEEF);
    stim_words.push_back(32'h12345678);
    runLoad(2, 0, -1);
    got = (wq0.size() > 0) ? wq0[0] : 'x;
    checkOutput("t1_word0", {24'd0, got}, {24'd0, 8'h00, 32'hDEADBEEF});
    got = (wq0.size() > 1) ? wq0[1] : 'x;
    checkOutput("t1_word1", {24'd0, got}, {24'd0, 8'h01, 32'h12345678});

    $display("[TB] zero-count timing");
    wq0.delete();
    pulseStart();
    applyStimulus(8'h00);
    applyStimulus(8'h00);
    checkOutput("t2_finish_done", done0, 0);
    checkOutput("t2_finish_hold", sched_hold0, 1);
    @(posedge clk);
    #1;
    checkOutput("t2_done_pulse", done0, 1);
    checkOutput("t2_hold_drop", sched_hold0, 0);
    @(posedge clk);
    #1;
    checkOutput("t2_done_once", done0, 0);
    checkOutput("t2_no_writes", wq0.size(), 0);

    $display("[TB] table vectors");
    foreach (vecs[i]) begin
      fillRandom(vecs[i].count);
      runLoad(vecs[i].count, vecs[i].gap, vecs[i].inject);
      checkOutput($sformatf("vec%0d_wr0", i), wq0.size(), vecs[i].exp_wr0);
      checkOutput($sformatf("vec%0d_wr1", i), wq1.size(), vecs[i].exp_wr1);
      checkOutput($sformatf("vec%0d_ovf0", i), overflow0, vecs[i].exp_ovf0[0]);
      checkOutput($sformatf("vec%0d_ovf1", i), overflow1, vecs[i].exp_ovf1[0]);
      if (vecs[i].inject >= 0)
        checkOutput($sformatf("vec%0d_fetch_addr0", i), imem[0], stim_words[0]);
    end

    $display("[TB] random loads");
    for (int r = 0; r < 8; r++) begin
      cnt = $urandom_range(0, 6);
      fillRandom(cnt);
      runLoad(cnt, $urandom_range(0, 2), -1);
    end

    $display("[TB] reset during load");
    wq0.delete();
    pulseStart();
    applyStimulus(8'h00);
    applyStimulus(8'h02);
    applyStimulus(8'hAA);
    applyStimulus(8'hBB);
    applyStimulus(8'hCC);
    applyStimulus(8'hDD);
    applyStimulus(8'h11);
    applyStimulus(8'h22);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("t5_byte_ready", byte_ready0, 0);
    checkOutput("t5_wr_en", wr_en0, 0);
    checkOutput("t5_wr_addr0", wr_addr0, 8'h00);
    checkOutput("t5_wr_addr1", wr_addr1, 8'hFE);
    checkOutput("t5_wr_data", wr_data0, 0);
    checkOutput("t5_hold", sched_hold0, 0);
    checkOutput("t5_done", done0, 0);
    checkOutput("t5_overflow1", overflow1, 0);
    reset = 1'b0;
    checkOutput("t5_partial_writes", wq0.size(), 1);
    got = (wq0.size() > 0) ? wq0[0] : 'x;
    checkOutput("t5_first_word", {24'd0, got}, {24'd0, 8'h00, 32'hAABBCCDD});
    @(posedge clk);
    #1;
    fillRandom(2);
    runLoad(2, 0, -1);
    checkOutput("t5_reload_addr0", imem[0], stim_words[0]);

    $display("[TB] start with reset");
    start = 1'b1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    reset = 1'b0;
    checkOutput("sr_hold", sched_hold0, 0);
    checkOutput("sr_byte_ready", byte_ready0, 0);
    @(posedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
